// File: rtl/aemb2_pipe_seq.sv
// AEMB2 pipeline sequencer: raises the data-stage enable once fetch, data bus,
// FSL and divider are all done for the current step, and tracks thread phase.
module aemb2_pipe_seq #(
  parameter int AEMB_HTX     = 1,
  parameter int AEMB_DIV_CYC = 32
) (
  input  logic        gclk,
  input  logic        grst,
  output logic        iwb_stb,
  input  logic        iwb_ack,
  input  logic        dwb_stb_ex,
  input  logic        dwb_ack,
  input  logic        fsl_stb_ex,
  input  logic        fsl_ack,
  input  logic        div_ex,
  output logic        dena,
  output logic        gpha,
  output logic        div_busy,
  output logic [15:0] stl_cnt
);

  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_RUN  = 2'd1,
    DIV_FIN  = 2'd2
  } div_state_e;

  localparam logic [5:0] DIV_LOAD = 6'(AEMB_DIV_CYC - 1);

  div_state_e  div_state_q, div_state_d;
  logic [5:0]  div_cnt_q, div_cnt_d;
  logic        ihold_q, ihold_d;
  logic        dhold_q, dhold_d;
  logic        fhold_q, fhold_d;
  logic        gpha_q, gpha_d;
  logic [15:0] stl_cnt_q, stl_cnt_d;

  logic div_fin;
  logic iok, dok, fok, xok;

  // Acks that land while the pipe is stalled are remembered in the hold flags
  // so the resource counts as done until the next advance.
  always_comb begin
    div_fin = (div_state_q == DIV_FIN);
    iok     = iwb_ack | ihold_q;
    dok     = ~dwb_stb_ex | dwb_ack | dhold_q;
    fok     = ~fsl_stb_ex | fsl_ack | fhold_q;
    xok     = ~div_ex | div_fin;
    dena    = ~grst & iok & dok & fok & xok;
    iwb_stb = ~grst & ~ihold_q;
  end

  always_comb begin
    ihold_d   = dena ? 1'b0 : (ihold_q | iwb_ack);
    dhold_d   = dena ? 1'b0 : (dhold_q | (dwb_ack & dwb_stb_ex));
    fhold_d   = dena ? 1'b0 : (fhold_q | (fsl_ack & fsl_stb_ex));
    gpha_d    = (AEMB_HTX != 0) ? (gpha_q ^ dena) : 1'b0;
    stl_cnt_d = stl_cnt_q;
    if (!dena && (stl_cnt_q != 16'hFFFF)) begin
      stl_cnt_d = stl_cnt_q + 16'd1;
    end
  end

  // RUN is left when the count would reach zero, so FIN (and with it dena)
  // lands exactly AEMB_DIV_CYC cycles after the first div_ex cycle.
  always_comb begin
    div_state_d = div_state_q;
    div_cnt_d   = div_cnt_q;
    unique case (div_state_q)
      DIV_IDLE: begin
        if (div_ex) begin
          div_state_d = DIV_RUN;
          div_cnt_d   = DIV_LOAD;
        end
      end
      DIV_RUN: begin
        if (!div_ex) begin
          div_state_d = DIV_IDLE;
          div_cnt_d   = 6'd0;
        end else if (div_cnt_q == 6'd1) begin
          div_state_d = DIV_FIN;
          div_cnt_d   = 6'd0;
        end else begin
          div_cnt_d = div_cnt_q - 6'd1;
        end
      end
      DIV_FIN: begin
        if (!div_ex || dena) begin
          div_state_d = DIV_IDLE;
        end
      end
      default: begin
        div_state_d = DIV_IDLE;
        div_cnt_d   = 6'd0;
      end
    endcase
  end

  always_ff @(posedge gclk) begin
    if (grst) begin
      div_state_q <= DIV_IDLE;
      div_cnt_q   <= 6'd0;
      ihold_q     <= 1'b0;
      dhold_q     <= 1'b0;
      fhold_q     <= 1'b0;
      gpha_q      <= 1'b0;
      stl_cnt_q   <= 16'd0;
    end else begin
      div_state_q <= div_state_d;
      div_cnt_q   <= div_cnt_d;
      ihold_q     <= ihold_d;
      dhold_q     <= dhold_d;
      fhold_q     <= fhold_d;
      gpha_q      <= gpha_d;
      stl_cnt_q   <= stl_cnt_d;
    end
  end

  assign gpha     = gpha_q;
  assign div_busy = (div_state_q != DIV_IDLE);
  assign stl_cnt  = stl_cnt_q;

endmodule

// File: tb/tb_aemb2_pipe_seq.sv
// Bench for aemb2_pipe_seq: a two-thread instance and a single-thread instance
// share one stimulus stream; vector table plus divider/reset/saturation sequences.
module tb_aemb2_pipe_seq;

  logic        gclk = 1'b0;
  logic        grst;
  logic        iwb_ack, dwb_stb_ex, dwb_ack, fsl_stb_ex, fsl_ack, div_ex;
  logic        iwb_stb0, dena0, gpha0, busy0;
  logic        iwb_stb1, dena1, gpha1, busy1;
  logic [15:0] stl0, stl1;

  int n_vec = 0;
  int n_err = 0;

  typedef struct packed {
    logic        rst, iack, dstb, dack, fstb, fack, dvx;
    logic        e_dena, e_stb, e_gpha, e_busy;
    logic [15:0] e_stl;
  } vec_t;

  vec_t tbl[21];

  // ---- clock ----
  always #5 gclk = ~gclk;

  aemb2_pipe_seq #(.AEMB_HTX(1), .AEMB_DIV_CYC(32)) u_dut (
    .gclk(gclk), .grst(grst), .iwb_stb(iwb_stb0), .iwb_ack(iwb_ack),
    .dwb_stb_ex(dwb_stb_ex), .dwb_ack(dwb_ack), .fsl_stb_ex(fsl_stb_ex),
    .fsl_ack(fsl_ack), .div_ex(div_ex), .dena(dena0), .gpha(gpha0),
    .div_busy(busy0), .stl_cnt(stl0)
  );

  aemb2_pipe_seq #(.AEMB_HTX(0), .AEMB_DIV_CYC(32)) u_dut_st (
    .gclk(gclk), .grst(grst), .iwb_stb(iwb_stb1), .iwb_ack(iwb_ack),
    .dwb_stb_ex(dwb_stb_ex), .dwb_ack(dwb_ack), .fsl_stb_ex(fsl_stb_ex),
    .fsl_ack(fsl_ack), .div_ex(div_ex), .dena(dena1), .gpha(gpha1),
    .div_busy(busy1), .stl_cnt(stl1)
  );

  // ---- driver tasks ----
  task automatic drive(input logic rst, input logic iack, input logic dstb,
                       input logic dack, input logic fstb, input logic fack,
                       input logic dvx);
    grst = rst; iwb_ack = iack; dwb_stb_ex = dstb; dwb_ack = dack;
    fsl_stb_ex = fstb; fsl_ack = fack; div_ex = dvx;
  endtask

  // ---- scoreboard ----
  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic ed, input logic es,
                         input logic eg, input logic eb, input logic [15:0] estl);
    chk({tag, " dena"},      16'(dena0),    16'(ed));
    chk({tag, " iwb_stb"},   16'(iwb_stb0), 16'(es));
    chk({tag, " gpha"},      16'(gpha0),    16'(eg));
    chk({tag, " div_busy"},  16'(busy0),    16'(eb));
    chk({tag, " stl_cnt"},   stl0,          estl);
    chk({tag, " st.dena"},   16'(dena1),    16'(ed));
    chk({tag, " st.iwb_stb"},16'(iwb_stb1), 16'(es));
    chk({tag, " st.gpha"},   16'(gpha1),    16'd0);
    chk({tag, " st.busy"},   16'(busy1),    16'(eb));
    chk({tag, " st.stl"},    stl1,          estl);
  endtask

  task automatic do_reset(input string tag);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge gclk);
    #4;
    chk_all(tag, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0);
    @(negedge gclk);
  endtask

  function automatic vec_t mk(input logic [6:0] in_b, input logic [3:0] ex_b,
                              input logic [15:0] estl);
    return {in_b, ex_b, estl};
  endfunction

  initial begin
    #1_500_000;
    $display("FAIL watchdog: time limit reached before summary");
    $fatal(1, "watchdog");
  end

  initial begin
    // inputs: rst iack dstb dack fstb fack dvx ; expect: dena stb gpha busy
    tbl[0]  = mk(7'b1000000, 4'b0000, 16'd0);
    tbl[1]  = mk(7'b0100000, 4'b1100, 16'd0);
    tbl[2]  = mk(7'b0100000, 4'b1110, 16'd0);
    tbl[3]  = mk(7'b0100000, 4'b1100, 16'd0);
    tbl[4]  = mk(7'b0100000, 4'b1110, 16'd0);
    tbl[5]  = mk(7'b1100000, 4'b0000, 16'd0);
    tbl[6]  = mk(7'b0010000, 4'b0100, 16'd0);
    tbl[7]  = mk(7'b0010000, 4'b0100, 16'd1);
    tbl[8]  = mk(7'b0110000, 4'b0100, 16'd2);
    tbl[9]  = mk(7'b0010000, 4'b0000, 16'd3);
    tbl[10] = mk(7'b0010000, 4'b0000, 16'd4);
    tbl[11] = mk(7'b0011000, 4'b1000, 16'd5);
    tbl[12] = mk(7'b0000000, 4'b0110, 16'd5);
    tbl[13] = mk(7'b0001000, 4'b0110, 16'd6);
    tbl[14] = mk(7'b0110000, 4'b0110, 16'd7);
    tbl[15] = mk(7'b0011000, 4'b1010, 16'd8);
    tbl[16] = mk(7'b0100100, 4'b0100, 16'd8);
    tbl[17] = mk(7'b0000110, 4'b1000, 16'd9);
    tbl[18] = mk(7'b0000000, 4'b0110, 16'd9);
    tbl[19] = mk(7'b0111110, 4'b1110, 16'd10);
    tbl[20] = mk(7'b0000000, 4'b0100, 16'd10);

    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge gclk);
    do_reset("rst0");

    for (int i = 0; i < 21; i++) begin
      drive(tbl[i].rst, tbl[i].iack, tbl[i].dstb, tbl[i].dack,
            tbl[i].fstb, tbl[i].fack, tbl[i].dvx);
      #4;
      chk_all($sformatf("tbl%0d", i), tbl[i].e_dena, tbl[i].e_stb,
              tbl[i].e_gpha, tbl[i].e_busy, tbl[i].e_stl);
      @(negedge gclk);
    end

    // divide starting at cycle 10, iwb_ack held high
    do_reset("rst_div");
    for (int c = 0; c <= 45; c++) begin
      logic ed, es, eg, eb;
      logic [15:0] estl;
      drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, (c >= 10) && (c <= 42));
      ed   = (c < 10) || (c >= 42);
      eb   = (c >= 11) && (c <= 42);
      es   = !((c >= 11) && (c <= 42));
      eg   = (c <= 10) ? 1'(c % 2) : (c <= 42) ? 1'b0 : 1'((c - 42) % 2);
      estl = (c <= 10) ? 16'd0 : (c <= 42) ? 16'(c - 10) : 16'd32;
      #4;
      chk_all($sformatf("div c%0d", c), ed, es, eg, eb, estl);
      @(negedge gclk);
    end

    // reset in the middle of a divide, then a fresh full-length divide
    do_reset("rst_mid");
    for (int c = 0; c < 20; c++) begin
      drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      @(negedge gclk);
    end
    drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    #4;
    chk("mid c20 dena", 16'(dena0), 16'd0);
    chk("mid c20 iwb_stb", 16'(iwb_stb0), 16'd0);
    chk("mid c20 busy", 16'(busy0), 16'd1);
    chk("mid c20 stl", stl0, 16'd20);
    @(negedge gclk);
    for (int c = 21; c <= 56; c++) begin
      logic ed, es, eg, eb;
      logic [15:0] estl;
      drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, c <= 53);
      ed   = (c >= 53);
      eb   = (c >= 22) && (c <= 53);
      es   = !((c >= 22) && (c <= 53));
      eg   = (c <= 53) ? 1'b0 : 1'((c - 53) % 2);
      estl = (c <= 53) ? 16'(c - 21) : 16'd32;
      #4;
      chk_all($sformatf("mid c%0d", c), ed, es, eg, eb, estl);
      @(negedge gclk);
    end

    // divide flushed while in RUN
    for (int c = 57; c <= 62; c++) begin
      drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, c <= 60);
      #4;
      chk($sformatf("flush c%0d busy", c), 16'(busy0), 16'((c >= 58) && (c <= 61)));
      chk($sformatf("flush c%0d dena", c), 16'(dena0), 16'(c >= 61));
      @(negedge gclk);
    end

    // stall counter saturation on a long FSL wait
    do_reset("rst_sat");
    repeat (70000) begin
      drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      @(negedge gclk);
    end
    #4;
    chk("sat stl", stl0, 16'hFFFF);
    chk("sat st.stl", stl1, 16'hFFFF);
    chk("sat dena", 16'(dena0), 16'd0);
    @(negedge gclk);
    drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    #4;
    chk("sat ack dena", 16'(dena0), 16'd1);
    chk("sat ack stl", stl0, 16'hFFFF);
    @(negedge gclk);
    drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    #4;
    chk("sat post dena", 16'(dena0), 16'd0);
    chk("sat post stl", stl0, 16'hFFFF);
    @(negedge gclk);
    #4;
    chk("sat hold stl", stl0, 16'hFFFF);
    chk("sat hold st.stl", stl1, 16'hFFFF);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
